// File: rtl/seg_pkg.sv
// seg_pkg -- shared definitions for the 7-segment scan controller.
//
// Segment bit order (active-high patterns): {a, b, c, d, e, f, g, dp}, so
// bit 7 = a ... bit 1 = g, bit 0 = dp. Patterns below never set dp; the
// decoder merges the per-digit decimal point into bit 0 separately.
// Outputs on the board are active-low; inversion happens in seg_decode.

package seg_pkg;

    localparam int SEG_BIT_A  = 7;
    localparam int SEG_BIT_B  = 6;
    localparam int SEG_BIT_C  = 5;
    localparam int SEG_BIT_D  = 4;
    localparam int SEG_BIT_E  = 3;
    localparam int SEG_BIT_F  = 2;
    localparam int SEG_BIT_G  = 1;
    localparam int SEG_BIT_DP = 0;

    localparam logic [7:0] SEG_0    = 8'hFC;
    localparam logic [7:0] SEG_1    = 8'h60;
    localparam logic [7:0] SEG_2    = 8'hDA;
    localparam logic [7:0] SEG_3    = 8'hF2;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'hB6;
    localparam logic [7:0] SEG_6    = 8'hBE;
    localparam logic [7:0] SEG_7    = 8'hE0;
    localparam logic [7:0] SEG_8    = 8'hFE;
    localparam logic [7:0] SEG_9    = 8'hF6;
    localparam logic [7:0] SEG_A    = 8'hEE;
    localparam logic [7:0] SEG_B    = 8'h3E;
    localparam logic [7:0] SEG_C    = 8'h9C;
    localparam logic [7:0] SEG_D    = 8'h7A;
    localparam logic [7:0] SEG_E    = 8'h9E;
    localparam logic [7:0] SEG_F    = 8'h8E;
    localparam logic [7:0] SEG_DASH = 8'h02;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    // Active-high glyph for a 4-bit code. Codes 10..15 render as hex letters
    // when hex_mode is set, otherwise as a dash (segment g only).
    function automatic logic [7:0] seg_pattern(input logic [3:0] code,
                                               input logic       hex_mode);
        logic [7:0] pat;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            4'd10:   pat = hex_mode ? SEG_A : SEG_DASH;
            4'd11:   pat = hex_mode ? SEG_B : SEG_DASH;
            4'd12:   pat = hex_mode ? SEG_C : SEG_DASH;
            4'd13:   pat = hex_mode ? SEG_D : SEG_DASH;
            4'd14:   pat = hex_mode ? SEG_E : SEG_DASH;
            default: pat = hex_mode ? SEG_F : SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// seg_decode -- combinational BCD/hex to 7-segment decoder.
//
// Ports:
//   code      in  4  digit code 0..15
//   dp        in  1  decimal point, 1 = lit
//   hex_mode  in  1  1: codes 10..15 as A,b,C,d,E,F; 0: as '-'
//   blank     in  1  1: all segments dark (dp included)
//   seg       out 8  {a,b,c,d,e,f,g,dp}, active-low

import seg_pkg::*;

module seg_decode (
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] pat;

    always_comb begin
        pat             = seg_pattern(code, hex_mode);
        pat[SEG_BIT_DP] = dp;
        if (blank) begin
            pat = SEG_OFF;
        end
        seg = ~pat;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- N-digit time-multiplexed 7-segment display controller.
//
// Holds a double-buffered digit word (shadow written by load, active used for
// display and swapped only at the frame wrap), scans one digit per refresh
// slot with an anti-ghosting dark window at the start of every slot, and
// drives registered active-low segment and anode outputs.
//
// Ports:
//   clk         in   1             system clock
//   rst_n       in   1             asynchronous active-low reset
//   load        in   1             capture digits_in/dp_in into the shadow word
//   digits_in   in   4*NUM_DIGITS  digit i = [4i+3:4i], digit 0 least significant
//   dp_in       in   NUM_DIGITS    decimal point per digit, 1 = lit
//   blank_lz    in   1             1 = suppress leading zeros
//   blink_mask  in   NUM_DIGITS    (SEG_SCAN_BLINK_EN only) digits that blink
//   seg_out     out  8             {a,b,c,d,e,f,g,dp}, active-low
//   an_out      out  NUM_DIGITS    anode enables, active-low, at most one low
//   frame_done  out  1             1-cycle pulse at end of the last digit slot
//
// Build option: define SEG_SCAN_BLINK_EN to add blink_mask and BLINK_FRAMES.

import seg_pkg::*;

module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GHOST_CYC   = 2,
    parameter int HEX_MODE    = 0
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        slot_cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] active_digits;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic                    pending;
    logic                    blank_lz_slot;

    logic                    slot_end;
    logic                    frame_wrap;
    logic                    in_ghost;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   blink_blank;
    logic                    lz_run;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [7:0]              dec_seg;
    logic [7:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    generate
        if (GHOST_CYC == 0) begin : g_no_ghost
            assign in_ghost = 1'b0;
        end else begin : g_ghost
            assign in_ghost = (slot_cnt < CNT_W'(GHOST_CYC));
        end
    endgenerate

`ifdef SEG_SCAN_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FR_W-1:0] frame_cnt;
    logic            blink_off;

    // Phase flips every BLINK_FRAMES completed frames; starts visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink_off <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_blank = blink_off ? blink_mask : '0;
`else
    assign blink_blank = '0;
`endif

    // Leading-zero mask: walk down from the top digit while digits are zero
    // with no dp; the first non-zero or dp-lit digit ends the run. Digit 0 is
    // never part of the run so a value of zero still shows one '0'.
    always_comb begin
        lz_mask = '0;
        lz_run  = blank_lz_slot;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && (active_digits[4*i +: 4] == 4'd0) && !active_dp[i]) begin
                lz_mask[i] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
    end

    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_nxt    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code  = active_digits[4*i +: 4];
                cur_dp    = active_dp[i];
                cur_blank = lz_mask[i] | blink_blank[i];
                an_nxt[i] = in_ghost;
            end
        end
    end

    seg_decode u_decode (
        .code     (cur_code),
        .dp       (cur_dp),
        .hex_mode (HEX_MODE != 0),
        .blank    (cur_blank),
        .seg      (dec_seg)
    );

    assign seg_nxt = in_ghost ? 8'hFF : dec_seg;

    // Scan position: slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt      <= '0;
            idx           <= '0;
            blank_lz_slot <= 1'b0;
        end else begin
            if (slot_end) begin
                slot_cnt      <= '0;
                idx           <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                blank_lz_slot <= blank_lz;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // Double buffer: the active word only changes at the frame wrap, so a
    // frame never shows a mix of old and new digits. A load landing on the
    // wrap itself is forwarded straight into the active word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            active_digits <= '0;
            active_dp     <= '0;
            pending       <= 1'b0;
        end else begin
            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
            end
            if (frame_wrap) begin
                pending <= 1'b0;
                if (load) begin
                    active_digits <= digits_in;
                    active_dp     <= dp_in;
                end else if (pending) begin
                    active_digits <= shadow_digits;
                    active_dp     <= shadow_dp;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Output register stage: pins lag the scan position by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= 8'hFF;
            an_out     <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_nxt;
            an_out     <= an_nxt;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (HEX_MODE 0 and 1) share all inputs.
// Expected digit slots are queued by the stimulus; a monitor pops one entry
// at the start of every lit slot and compares both instances.

module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  seg0, seg1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;
`ifdef SEG_SCAN_BLINK_EN
    logic [3:0]  blink_mask;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] s0;
        logic [7:0] s1;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS (4), .REFRESH_DIV (8), .GHOST_CYC (2), .HEX_MODE (0)
`ifdef SEG_SCAN_BLINK_EN
        , .BLINK_FRAMES (2)
`endif
    ) u0 (
        .clk (clk), .rst_n (rst_n), .load (load), .digits_in (digits_in),
        .dp_in (dp_in), .blank_lz (blank_lz),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg_out (seg0), .an_out (an0), .frame_done (fd0)
    );

    seg_scan_ctrl #(
        .NUM_DIGITS (4), .REFRESH_DIV (8), .GHOST_CYC (2), .HEX_MODE (1)
`ifdef SEG_SCAN_BLINK_EN
        , .BLINK_FRAMES (2)
`endif
    ) u1 (
        .clk (clk), .rst_n (rst_n), .load (load), .digits_in (digits_in),
        .dp_in (dp_in), .blank_lz (blank_lz),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg_out (seg1), .an_out (an1), .frame_done (fd1)
    );

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   last_fd = 0;
    bit   fd_seen = 0;
    bit   prev_lit = 0;
    int   ghost_run = 0;
    exp_t e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            fd_seen   = 0;
            prev_lit  = 0;
            ghost_run = 0;
        end else begin
            if (an0 == 4'hF) begin
                check8("dark_seg", seg0, 8'hFF);
            end else begin
                check8("one_anode", 8'($countones(~an0)), 8'd1);
            end
            if (fd0) begin
                if (fd_seen) check8("frame_period", 8'(cyc - last_fd), 8'd32);
                check8("fd_same_u1", {7'd0, fd1}, 8'd1);
                fd_seen = 1;
                last_fd = cyc;
            end
            if (an0 != 4'hF) begin
                if (!prev_lit && q.size() > 0) begin
                    e = q.pop_front();
                    check8("an_u0", {4'd0, an0}, {4'd0, e.an});
                    check8("seg_u0", seg0, e.s0);
                    check8("an_u1", {4'd0, an1}, {4'd0, e.an});
                    check8("seg_u1", seg1, e.s1);
                    check8("ghost_len", 8'(ghost_run), 8'd2);
                end
                ghost_run = 0;
                prev_lit  = 1;
            end else begin
                ghost_run++;
                prev_lit = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd0 && n < 200);
        if (!fd0) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout got 0 want 1");
        end
    endtask

    // s0/s1 packed {digit3, digit2, digit1, digit0} for u0/u1.
    task automatic push_frame(input logic [31:0] s0, input logic [31:0] s1);
        exp_t x;
        for (int i = 0; i < 4; i++) begin
            x.an = ~(4'b0001 << i);
            x.s0 = s0[8*i +: 8];
            x.s1 = s1[8*i +: 8];
            q.push_back(x);
        end
    endtask

    task automatic expect_frame(input logic [31:0] s0, input logic [31:0] s1);
        wait_fd();
        push_frame(s0, s1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        repeat (5) @(negedge clk);
        digits_in = d;
        dp_in     = dp;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

`ifdef SEG_SCAN_BLINK_EN
    bit vis[8];
`endif

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        blank_lz  = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        blink_mask = '0;
`endif
        repeat (3) @(negedge clk);
        check8("rst_seg", seg0, 8'hFF);
        check8("rst_an", {4'd0, an0}, 8'h0F);
        check8("rst_fd", {7'd0, fd0}, 8'h00);
        rst_n = 1'b1;

        // Reset asserted mid-scan while a digit is lit.
        repeat (13) @(negedge clk);
        check8("pre_rst_lit", 8'(an0 != 4'hF), 8'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check8("mid_rst_seg", seg0, 8'hFF);
        check8("mid_rst_an", {4'd0, an0}, 8'h0F);
        check8("mid_rst_fd", {7'd0, fd0}, 8'h00);
        rst_n = 1'b1;

        do_load(16'h1234, 4'b0000);
        expect_frame(32'h9F250D99, 32'h9F250D99);

        blank_lz = 1'b1;
        do_load(16'h0005, 4'b0000);
        expect_frame(32'hFFFFFF49, 32'hFFFFFF49);

        do_load(16'h0000, 4'b0000);
        expect_frame(32'hFFFFFF03, 32'hFFFFFF03);

        // Loaded mid-frame while zeros are still on display.
        do_load(16'h1111, 4'b0000);
        expect_frame(32'h9F9F9F9F, 32'h9F9F9F9F);

        // Load exactly on the next wrap: must show in the very next frame.
        repeat (31) @(posedge clk);
        @(negedge clk);
        digits_in = 16'h5678;
        dp_in     = 4'b0000;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        check8("wrap_fd", {7'd0, fd0}, 8'h01);
        push_frame(32'h49411F01, 32'h49411F01);

        // dp on digit 2 stops zero blanking; dp on digit 0 with dash / 'A'.
        do_load(16'h000A, 4'b0101);
        expect_frame(32'hFF0203FC, 32'hFF020310);

        do_load(16'hFEDB, 4'b0000);
        expect_frame(32'hFDFDFDFD, 32'h716185C1);

        wait_fd();
        check8("queue_drained", 8'(q.size()), 8'd0);

`ifdef SEG_SCAN_BLINK_EN
        blink_mask = 4'b0001;
        for (int f = 0; f < 8; f++) begin
            wait_fd();
            repeat (4) @(negedge clk);
            check8("blink_an0", {4'd0, an0}, 8'h0E);
            vis[f] = (seg0 != 8'hFF);
            repeat (8) @(negedge clk);
            check8("blink_an1", {4'd0, an0}, 8'h0D);
            check8("blink_other", seg0, 8'hFD);
        end
        for (int f = 0; f < 6; f++) begin
            check8("blink_phase", {7'd0, vis[f]}, {7'd0, ~vis[f+2]});
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
